// File: rtl/coherent_dcache_agent.sv
// Direct-mapped, one-word-per-line MSI data cache with snoop responder and bus initiator.
// Define DCACHE_STATS_EN to add hit_count / miss_count outputs.
module coherent_dcache_agent #(
    parameter int unsigned SETS  = 16,
    parameter int unsigned CPUID = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    output logic        cctrans,
    output logic        ccwrite,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    if (SETS < 2 || SETS > 256 || (SETS & (SETS - 1)) != 0) begin : g_bad_sets
        $error("SETS must be a power of two between 2 and 256");
    end
    if (CPUID > 255) begin : g_bad_cpuid
        $error("CPUID must fit in 8 bits");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_WB, ST_FETCH, ST_SNOOP} fsm_t;
    typedef enum logic [1:0] {L_I, L_S, L_M} msi_t;

    fsm_t             state_q, state_d;
    msi_t             line_state_q [SETS];
    msi_t             line_state_d [SETS];
    logic [TAG_W-1:0] line_tag_q   [SETS];
    logic [TAG_W-1:0] line_tag_d   [SETS];
    logic [31:0]      line_data_q  [SETS];
    logic [31:0]      line_data_d  [SETS];
    logic             snp_inv_q, snp_inv_d;
    logic [31:0]      snp_addr_q, snp_addr_d;

    logic [IDX_W-1:0] cpu_idx, snp_idx;
    logic [TAG_W-1:0] cpu_tag, snp_tag;
    logic             cpu_hit, snp_match;

    assign cpu_idx   = dmemaddr[IDX_W+1:2];
    assign cpu_tag   = dmemaddr[31:IDX_W+2];
    assign snp_idx   = snp_addr_q[IDX_W+1:2];
    assign snp_tag   = snp_addr_q[31:IDX_W+2];
    assign cpu_hit   = (line_state_q[cpu_idx] != L_I) && (line_tag_q[cpu_idx] == cpu_tag);
    assign snp_match = (line_state_q[snp_idx] != L_I) && (line_tag_q[snp_idx] == snp_tag);

    always_comb begin
        state_d      = state_q;
        line_state_d = line_state_q;
        line_tag_d   = line_tag_q;
        line_data_d  = line_data_q;
        snp_inv_d    = snp_inv_q;
        snp_addr_d   = snp_addr_q;
        dhit         = 1'b0;
        dmemload     = '0;
        dREN         = 1'b0;
        dWEN         = 1'b0;
        daddr        = '0;
        dstore       = '0;
        cctrans      = 1'b0;
        ccwrite      = 1'b0;

        // A snoop seen in IDLE/WB/FETCH wins outright; the CPU request replays from IDLE.
        if (ccwait && state_q != ST_SNOOP) begin
            state_d    = ST_SNOOP;
            snp_inv_d  = ccinv;
            snp_addr_d = ccsnoopaddr;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        if (cpu_hit && (dmemREN || line_state_q[cpu_idx] == L_M)) begin
                            dhit = 1'b1;
                            if (dmemREN) dmemload = line_data_q[cpu_idx];
                            else         line_data_d[cpu_idx] = dmemstore;
                        end else if (!cpu_hit && line_state_q[cpu_idx] == L_M) begin
                            state_d = ST_WB;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    dWEN   = 1'b1;
                    daddr  = {line_tag_q[cpu_idx], cpu_idx, 2'b00};
                    dstore = line_data_q[cpu_idx];
                    if (!dwait) begin
                        line_state_d[cpu_idx] = L_I;
                        state_d               = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    dREN    = 1'b1;
                    cctrans = 1'b1;
                    ccwrite = dmemWEN;
                    daddr   = dmemaddr;
                    if (!dwait) begin
                        dhit                = 1'b1;
                        line_tag_d[cpu_idx] = cpu_tag;
                        if (dmemWEN) begin
                            line_data_d[cpu_idx]  = dmemstore;
                            line_state_d[cpu_idx] = L_M;
                        end else begin
                            line_data_d[cpu_idx]  = dload;
                            line_state_d[cpu_idx] = L_S;
                            dmemload              = dload;
                        end
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    if (snp_match && line_state_q[snp_idx] == L_M) begin
                        cctrans = 1'b1;
                        ccwrite = 1'b1;
                        dWEN    = 1'b1;
                        daddr   = snp_addr_q;
                        dstore  = line_data_q[snp_idx];
                    end
                    if (!ccwait) begin
                        if (snp_match) begin
                            if (snp_inv_q)                              line_state_d[snp_idx] = L_I;
                            else if (line_state_q[snp_idx] == L_M)      line_state_d[snp_idx] = L_S;
                        end
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end

        if (!nRST) begin
            dhit     = 1'b0;
            dmemload = '0;
            dREN     = 1'b0;
            dWEN     = 1'b0;
            daddr    = '0;
            dstore   = '0;
            cctrans  = 1'b0;
            ccwrite  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            line_state_q <= '{default: L_I};
            snp_inv_q    <= 1'b0;
            snp_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            line_state_q <= line_state_d;
            line_tag_q   <= line_tag_d;
            line_data_q  <= line_data_d;
            snp_inv_q    <= snp_inv_d;
            snp_addr_q   <= snp_addr_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic        replay_q, replay_d;

    // A miss counts once as it leaves IDLE (via WB or FETCH); replays after preemption do not.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        replay_d   = replay_q;
        if (state_q == ST_IDLE && dhit) hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == ST_IDLE && (state_d == ST_WB || state_d == ST_FETCH) && !replay_q)
            miss_cnt_d = miss_cnt_q + 32'd1;
        if ((state_q == ST_WB || state_q == ST_FETCH) && state_d == ST_SNOOP) replay_d = 1'b1;
        else if (dhit)                                                      replay_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            replay_q   <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            replay_q   <= replay_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule
